// File: rtl/legv8_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// legv8_multicycle_ctrl
//   Multi-cycle control sequencer for the RFALUDM datapath (register file +
//   ALU + data memory). Accepts one LEGv8 instruction at a time over a
//   valid/ready handshake, latches it into IR and walks DECODE/EXEC/MEM/WB,
//   driving register selects, ALU controls and memory strobes. Supports
//   ADD/SUB/AND/ORR (R-type), LDUR, STUR and CBZ.
//
// Ports
//   clock, reset_n  : rising-edge clock, asynchronous active-low reset
//   InstrValid/Ready: instruction handshake (Ready only in IDLE)
//   Instruction     : 32-bit instruction word, latched on transfer
//   Zero            : ALU zero flag, sampled when CBZ leaves EXEC
//   Read1/Read2     : RF read selects (zero-extended 5-bit fields)
//   WriteReg        : RF write select
//   ALUOp           : 00 add, 01 pass/compare, 10 R-type via OpCodefield
//   OpCodefield     : IR[31:21]
//   AluSrc          : 00 register, 01 sign-extended SEin
//   SEin            : raw D-format offset IR[20:12]
//   RegWrite/MemRead/MemWrite/MemToReg : datapath strobes
//   BranchTaken     : CBZ outcome, valid while Done=1
//   Done            : one-cycle completion pulse
//   IllegalOp       : one-cycle pulse for an undecodable instruction
// -----------------------------------------------------------------------------
module legv8_multicycle_ctrl #(
  parameter logic [10:0] OP_ADD  = 11'h458,
  parameter logic [10:0] OP_SUB  = 11'h658,
  parameter logic [10:0] OP_AND  = 11'h450,
  parameter logic [10:0] OP_ORR  = 11'h550,
  parameter logic [10:0] OP_LDUR = 11'h7C2,
  parameter logic [10:0] OP_STUR = 11'h7C0,
  parameter logic [7:0]  OP_CBZ  = 8'hB4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  output logic [5:0]  Read1,
  output logic [5:0]  Read2,
  output logic [5:0]  WriteReg,
  output logic [1:0]  ALUOp,
  output logic [10:0] OpCodefield,
  output logic [1:0]  AluSrc,
  output logic [8:0]  SEin,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        BranchTaken,
  output logic        Done,
  output logic        IllegalOp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_done;
  logic        r_illegal;
  logic        r_branch;

  // Instruction classification, purely from the latched IR.
  logic [10:0] w_opc;
  logic        w_is_r;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_cbz;
  logic        w_legal;

  assign w_opc    = r_ir[31:21];
  assign w_is_r   = (w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                    (w_opc == OP_AND) || (w_opc == OP_ORR);
  assign w_is_ld  = (w_opc == OP_LDUR);
  assign w_is_st  = (w_opc == OP_STUR);
  assign w_is_cbz = (r_ir[31:24] == OP_CBZ);
  assign w_legal  = w_is_r || w_is_ld || w_is_st || w_is_cbz;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: IR sits inside the async reset on purpose: a cleared IR keeps
  // OpCodefield and the decoded selects at 0 after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_branch  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && InstrValid) begin
        r_ir <= Instruction;
      end
      // Completion flags are registered so they appear in the first IDLE
      // cycle, alongside InstrReady, enabling back-to-back accepts.
      r_done    <= (r_state == S_EXEC && w_is_cbz) ||
                   (r_state == S_MEM  && w_is_st)  ||
                   (r_state == S_WB);
      r_illegal <= (r_state == S_DECODE) && !w_legal;
      r_branch  <= (r_state == S_EXEC) && w_is_cbz && Zero;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (InstrValid) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (w_is_r)                  w_next = S_WB;
        else if (w_is_ld || w_is_st) w_next = S_MEM;
        else                         w_next = S_IDLE;
      end
      S_MEM:    w_next = w_is_ld ? S_WB : S_IDLE;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath controls: decoded from IR + state only (no input paths), held
  // constant from DECODE to completion and forced to 0 in IDLE.
  logic w_active;
  assign w_active = (r_state != S_IDLE);

  always_comb begin
    Read1       = '0;
    Read2       = '0;
    WriteReg    = '0;
    ALUOp       = 2'b00;
    AluSrc      = 2'b00;
    SEin        = '0;
    MemToReg    = 1'b0;
    OpCodefield = '0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    if (w_active) begin
      OpCodefield = r_ir[31:21];
      if (w_is_r) begin
        Read1    = {1'b0, r_ir[9:5]};
        Read2    = {1'b0, r_ir[20:16]};
        WriteReg = {1'b0, r_ir[4:0]};
        ALUOp    = 2'b10;
        RegWrite = (r_state == S_WB);
      end else if (w_is_ld) begin
        Read1    = {1'b0, r_ir[9:5]};
        WriteReg = {1'b0, r_ir[4:0]};
        SEin     = r_ir[20:12];
        AluSrc   = 2'b01;
        MemToReg = 1'b1;
        MemRead  = (r_state == S_MEM) || (r_state == S_WB);
        RegWrite = (r_state == S_WB);
      end else if (w_is_st) begin
        Read1    = {1'b0, r_ir[9:5]};
        Read2    = {1'b0, r_ir[4:0]};
        SEin     = r_ir[20:12];
        AluSrc   = 2'b01;
        MemWrite = (r_state == S_MEM);
      end else if (w_is_cbz) begin
        Read2    = {1'b0, r_ir[4:0]};
        ALUOp    = 2'b01;
      end
    end
  end

  assign InstrReady  = (r_state == S_IDLE);
  assign Done        = r_done;
  assign IllegalOp   = r_illegal;
  assign BranchTaken = r_branch;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_legv8_multicycle_ctrl
//   Table-driven bench: each record holds an instruction, the Zero value to
//   present and the hand-computed expected selects, strobe counts/cycles and
//   completion timing (cycle k = k-th rising edge after the accept edge).
//   Hand-written sequences cover back-to-back accept and reset mid-STUR.
// -----------------------------------------------------------------------------
module tb_legv8_multicycle_ctrl;

  logic        clock;
  logic        reset_n;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic        Zero;
  logic [5:0]  Read1, Read2, WriteReg;
  logic [1:0]  ALUOp, AluSrc;
  logic [10:0] OpCodefield;
  logic [8:0]  SEin;
  logic        RegWrite, MemRead, MemWrite, MemToReg;
  logic        BranchTaken, Done, IllegalOp;

  legv8_multicycle_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instruction (Instruction),
    .Zero        (Zero),
    .Read1       (Read1),
    .Read2       (Read2),
    .WriteReg    (WriteReg),
    .ALUOp       (ALUOp),
    .OpCodefield (OpCodefield),
    .AluSrc      (AluSrc),
    .SEin        (SEin),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg),
    .BranchTaken (BranchTaken),
    .Done        (Done),
    .IllegalOp   (IllegalOp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [5:0]  read1;
    logic [5:0]  read2;
    logic [5:0]  wreg;
    logic [1:0]  aluop;
    logic [1:0]  alusrc;
    logic [8:0]  sein;
    logic        m2r;
    logic [10:0] opc;
    int          done_cyc;  // 0 = no Done expected
    int          ill_cyc;   // 0 = no IllegalOp expected
    int          rw_n;
    int          rw_first;
    int          mr_n;
    int          mr_first;
    int          mw_n;
    int          mw_first;
    logic        branch;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v, input int idx);
    int rw_n = 0, rw_first = 0, mr_n = 0, mr_first = 0, mw_n = 0, mw_first = 0;
    int done_n = 0, done_cyc = 0, ill_n = 0, ill_cyc = 0, br_bad = 0;
    logic br_at_done = 1'b0;
    @(negedge clock);
    check($sformatf("v%0d_ready_pre", idx), 32'(InstrReady), 32'd1);
    Instruction = v.instr;
    InstrValid  = 1'b1;
    Zero        = v.zero;
    @(posedge clock);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) begin
        InstrValid  = 1'b0;
        Instruction = 32'h0;
        check($sformatf("v%0d_read1", idx),  32'(Read1),       32'(v.read1));
        check($sformatf("v%0d_read2", idx),  32'(Read2),       32'(v.read2));
        check($sformatf("v%0d_wreg", idx),   32'(WriteReg),    32'(v.wreg));
        check($sformatf("v%0d_aluop", idx),  32'(ALUOp),       32'(v.aluop));
        check($sformatf("v%0d_alusrc", idx), 32'(AluSrc),      32'(v.alusrc));
        check($sformatf("v%0d_sein", idx),   32'(SEin),        32'(v.sein));
        check($sformatf("v%0d_m2r", idx),    32'(MemToReg),    32'(v.m2r));
        check($sformatf("v%0d_opc", idx),    32'(OpCodefield), 32'(v.opc));
        check($sformatf("v%0d_ready_dec", idx), 32'(InstrReady), 32'd0);
      end
      if (RegWrite) begin rw_n++; if (rw_first == 0) rw_first = k; end
      if (MemRead)  begin mr_n++; if (mr_first == 0) mr_first = k; end
      if (MemWrite) begin mw_n++; if (mw_first == 0) mw_first = k; end
      if (Done) begin done_n++; done_cyc = k; br_at_done = BranchTaken; end
      else if (BranchTaken) br_bad++;
      if (IllegalOp) begin
        ill_n++; ill_cyc = k;
        check($sformatf("v%0d_ready_ill", idx), 32'(InstrReady), 32'd1);
      end
    end
    check($sformatf("v%0d_done_n", idx),   32'(done_n),   (v.done_cyc != 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_done_cyc", idx), 32'(done_cyc), 32'(v.done_cyc));
    check($sformatf("v%0d_ill_n", idx),    32'(ill_n),    (v.ill_cyc != 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_ill_cyc", idx),  32'(ill_cyc),  32'(v.ill_cyc));
    check($sformatf("v%0d_rw_n", idx),     32'(rw_n),     32'(v.rw_n));
    check($sformatf("v%0d_rw_first", idx), 32'(rw_first), 32'(v.rw_first));
    check($sformatf("v%0d_mr_n", idx),     32'(mr_n),     32'(v.mr_n));
    check($sformatf("v%0d_mr_first", idx), 32'(mr_first), 32'(v.mr_first));
    check($sformatf("v%0d_mw_n", idx),     32'(mw_n),     32'(v.mw_n));
    check($sformatf("v%0d_mw_first", idx), 32'(mw_first), 32'(v.mw_first));
    check($sformatf("v%0d_branch", idx),   32'(br_at_done), 32'(v.branch));
    check($sformatf("v%0d_br_idle", idx),  32'(br_bad),   32'd0);
  endtask

  initial begin
    int k;
    int bad;
    //          instr         z  r1 r2 wr aluop  src    sein    m2r opc      dn il rw rwf mr mrf mw mwf br
    vecs[0] = '{32'h8B020023, 0, 1, 2, 3, 2'b10, 2'b00, 9'h000, 0, 11'h458, 4, 0, 1, 3, 0, 0, 0, 0, 0}; // ADD X3,X1,X2
    vecs[1] = '{32'hCB0C016A, 0, 11,12,10,2'b10, 2'b00, 9'h000, 0, 11'h658, 4, 0, 1, 3, 0, 0, 0, 0, 0}; // SUB X10,X11,X12
    vecs[2] = '{32'h8A030041, 0, 2, 3, 1, 2'b10, 2'b00, 9'h000, 0, 11'h450, 4, 0, 1, 3, 0, 0, 0, 0, 0}; // AND X1,X2,X3
    vecs[3] = '{32'hAA1D03DF, 0, 30,29,31,2'b10, 2'b00, 9'h000, 0, 11'h550, 4, 0, 1, 3, 0, 0, 0, 0, 0}; // ORR X31,X30,X29
    vecs[4] = '{32'hF8428005, 0, 0, 0, 5, 2'b00, 2'b01, 9'h028, 1, 11'h7C2, 5, 0, 1, 4, 2, 3, 0, 0, 0}; // LDUR X5,[X0,#40]
    vecs[5] = '{32'hF81F8007, 0, 0, 7, 0, 2'b00, 2'b01, 9'h1F8, 0, 11'h7C0, 4, 0, 0, 0, 0, 0, 1, 3, 0}; // STUR X7,[X0,#-8]
    vecs[6] = '{32'hB4000044, 1, 0, 4, 0, 2'b01, 2'b00, 9'h000, 0, 11'h5A0, 3, 0, 0, 0, 0, 0, 0, 0, 1}; // CBZ X4, Zero=1
    vecs[7] = '{32'hB4000044, 0, 0, 4, 0, 2'b01, 2'b00, 9'h000, 0, 11'h5A0, 3, 0, 0, 0, 0, 0, 0, 0, 0}; // CBZ X4, Zero=0
    vecs[8] = '{32'hFFFFFFFF, 0, 0, 0, 0, 2'b00, 2'b00, 9'h000, 0, 11'h7FF, 0, 2, 0, 0, 0, 0, 0, 0, 0}; // illegal

    reset_n     = 1'b0;
    InstrValid  = 1'b0;
    Instruction = 32'h0;
    Zero        = 1'b0;
    #23;
    check("rst_ready",   32'(InstrReady),  32'd1);
    check("rst_done",    32'(Done),        32'd0);
    check("rst_strobes", 32'({RegWrite, MemRead, MemWrite, MemToReg, IllegalOp, BranchTaken}), 32'd0);
    check("rst_opc",     32'(OpCodefield), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Back-to-back: CBZ (Zero=1) then ADD accepted in the CBZ Done cycle.
    @(negedge clock);
    Instruction = 32'hB4000044;
    InstrValid  = 1'b1;
    Zero        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    InstrValid = 1'b0;
    k = 1;
    while (!Done && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("b2b_cbz_done_cyc", 32'(k), 32'd3);
    check("b2b_cbz_branch",   32'(BranchTaken), 32'd1);
    check("b2b_ready_in_done", 32'(InstrReady), 32'd1);
    Instruction = 32'h8B020023;
    InstrValid  = 1'b1;
    Zero        = 1'b0;
    @(posedge clock);
    @(negedge clock);
    InstrValid = 1'b0;
    check("b2b_add_read1", 32'(Read1),       32'd1);
    check("b2b_add_wreg",  32'(WriteReg),    32'd3);
    check("b2b_add_opc",   32'(OpCodefield), 32'h458);
    check("b2b_add_done_clr", 32'(Done),     32'd0);
    k = 1;
    while (!Done && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("b2b_add_done_cyc", 32'(k), 32'd4);
    check("b2b_add_branch",   32'(BranchTaken), 32'd0);

    // Reset during STUR MEM: MemWrite must drop without a clock edge.
    @(negedge clock);
    Instruction = 32'hF81F8007;
    InstrValid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    InstrValid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rstmid_memwrite_hi", 32'(MemWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_memwrite_lo", 32'(MemWrite), 32'd0);
    check("rstmid_ready",       32'(InstrReady), 32'd1);
    check("rstmid_read2",       32'(Read2), 32'd0);
    check("rstmid_opc",         32'(OpCodefield), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (Done || !InstrReady || RegWrite || MemRead || MemWrite || IllegalOp) bad++;
    end
    check("rstmid_quiet_after", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
Multi-cycle control sequencer that issues control to the RFALUDM datapath (register file + ALU + data memory) for one instruction at a time.
- Accepts a 32-bit LEGv8 instruction over a valid/ready handshake and latches it.
- Decodes R-type ADD/SUB/AND/ORR, LDUR, STUR and CBZ.
- Steps through DECODE/EXEC/MEM/WB, driving RFALUDM's register-select, ALU and memory strobes.
- Returns branch outcome and completion status.

Parameters:
OP_ADD, 11'h458, R-type ADD opcode
OP_SUB, 11'h658, R-type SUB opcode
OP_AND, 11'h450, R-type AND opcode
OP_ORR, 11'h550, R-type ORR opcode
OP_LDUR, 11'h7C2, load opcode
OP_STUR, 11'h7C0, store opcode
OP_CBZ, 8'hB4, CBZ opcode (Instruction[31:24])

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
InstrValid  in  1  Instruction is valid
InstrReady  out  1  controller can accept an instruction
Instruction  in  32  LEGv8 instruction word
Zero  in  1  ALU zero flag from RFALUDM
Read1  out  6  RF read port 1 select, zero-extended 5-bit field
Read2  out  6  RF read port 2 select
WriteReg  out  6  RF write select
ALUOp  out  2  00 add, 01 pass/compare (CBZ), 10 R-type via OpCodefield
OpCodefield  out  11  Instruction[31:21] of latched instruction
AluSrc  out  2  00 register operand, 01 sign-extended SEin; 10/11 never driven
SEin  out  9  D-format offset Instruction[20:12], raw (datapath sign-extends)
RegWrite  out  1  RF write strobe
MemRead  out  1  data memory read enable
MemWrite  out  1  data memory write strobe
MemToReg  out  1  1 = write-back from memory, 0 = from ALU
BranchTaken  out  1  CBZ outcome, valid while Done=1
Done  out  1  one-cycle completion pulse
IllegalOp  out  1  one-cycle pulse for undecodable instruction

Behaviour:
Reset:
- reset_n low asynchronously forces state IDLE and clears the instruction register (IR).
- All outputs go to 0, except InstrReady=1 once in IDLE.
- Reset mid-instruction drops all strobes immediately; the instruction is lost and no Done is issued.

Handshake:
- InstrReady=1 only in IDLE.
- Transfer occurs on a rising edge with InstrValid && InstrReady; Instruction is latched into IR.
- Instruction is ignored in all other states.

States:
- IDLE -> DECODE on transfer.
- DECODE: classify IR.
  - Illegal -> IDLE, with IllegalOp pulsed in the first IDLE cycle.
  - Otherwise -> EXEC.
- EXEC:
  - R-type -> WB.
  - LDUR/STUR -> MEM.
  - CBZ -> IDLE, with Zero registered into BranchTaken.
- MEM: LDUR -> WB; STUR -> IDLE.
- WB -> IDLE.

Done:
- Registered pulse in the first IDLE cycle after a legal instruction completes.
- InstrReady is also 1 in that cycle, so a back-to-back accept is allowed.
- BranchTaken is 0 except while Done=1 after CBZ.

Per-opcode output values (all derived from IR and state, glitch-free, held from DECODE to completion):
- R-type:
  - Read1=Rn[9:5], Read2=Rm[20:16], WriteReg=Rd[4:0].
  - ALUOp=10, AluSrc=00, MemToReg=0.
- LDUR:
  - Read1=Rn, WriteReg=Rt[4:0], SEin=IR[20:12].
  - ALUOp=00, AluSrc=01, MemToReg=1.
  - MemRead=1 in MEM and WB.
- STUR:
  - Read1=Rn, Read2=Rt, SEin=IR[20:12].
  - ALUOp=00, AluSrc=01.
  - MemWrite=1 only in MEM, exactly one cycle.
- CBZ:
  - Read2=Rt, ALUOp=01, AluSrc=00.
  - Zero is sampled only at the EXEC->IDLE edge.
- RegWrite=1 only in WB (R-type, LDUR); never for STUR, CBZ or illegal instructions.
- RegWrite, MemRead and MemWrite are never asserted in IDLE or DECODE.

Latency from accept edge to Done: R-type 4, LDUR 5, STUR 4, CBZ 3 cycles. Illegal instructions reach IDLE in 2 cycles.

Test Plan:
- ADD X3,X1,X2 (0x8B020023) -> Read1=1, Read2=2, WriteReg=3, OpCodefield=0x458, ALUOp=10; RegWrite high exactly in cycle 3 after accept; Done pulse in cycle 4.
- LDUR X5,[X0,#40] (0xF8428005) -> SEin=9'h028, AluSrc=01, ALUOp=00, WriteReg=5; MemRead high 2 cycles; RegWrite and MemToReg=1 in WB; Done at cycle 5.
- STUR X7,[X0,#-8] (0xF81F8007) -> SEin=9'h1F8, Read2=7; MemWrite high exactly 1 cycle; RegWrite never; Done at cycle 4.
- CBZ X4 (0xB4000044):
  - With Zero=1 in EXEC -> BranchTaken=1 with Done at cycle 3.
  - Repeat with Zero=0 -> BranchTaken=0.
  - Back-to-back accept in the Done cycle succeeds.
- 0xFFFFFFFF -> IllegalOp one-cycle pulse, no RegWrite/MemRead/MemWrite, no Done, InstrReady=1 after 2 cycles.
- STUR accepted, reset_n low during MEM -> MemWrite falls without a clock edge; after release InstrReady=1, outputs 0, no Done.
